// File: rtl/mp_addsub.sv
// Multi-precision add/sub with optional modular reduction, processed one
// CHUNK_SIZE slice per cycle over one pass (plain) or two passes (modular).
module mp_addsub #(
  parameter int OPERAND_WIDTH = 512,
  parameter int CHUNK_SIZE    = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [OPERAND_WIDTH-1:0] in_a,
  input  logic [OPERAND_WIDTH-1:0] in_b,
  input  logic [OPERAND_WIDTH-1:0] in_m,
  output logic [OPERAND_WIDTH:0]   result,
  output logic                     done,
  output logic                     busy
);

  localparam int W  = OPERAND_WIDTH;
  localparam int C  = CHUNK_SIZE;
  localparam int N  = W / C;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (((W % C) != 0) || (C < 8)) begin : g_bad_params
      $fatal(1, "mp_addsub: OPERAND_WIDTH must be a multiple of CHUNK_SIZE and CHUNK_SIZE >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_m;
  logic [W-1:0]    r_s;
  logic [W-1:0]    r_t;
  logic [1:0]      r_mode;
  logic            r_carry;
  logic            r_c1;
  logic [CW-1:0]   r_cnt;
  logic [W:0]      r_result;

  logic            w_pass2;
  logic            w_last;
  logic [C-1:0]    w_x;
  logic [C-1:0]    w_y;
  logic [C:0]      w_chunk;
  logic [W-1:0]    w_s_shift;
  logic [W-1:0]    w_s_rot;
  logic [W-1:0]    w_t_shift;
  logic            w_take_t;
  logic [W:0]      w_pass1_res;
  logic [W:0]      w_pass2_res;

  // Shared C-bit adder: PASS1 adds b (or ~b), PASS2 adds ~m (mode 10) or m (mode 11).
  always_comb begin
    w_pass2 = (r_state == PASS2);
    w_last  = (r_cnt == CW'(N - 1));
    w_x     = w_pass2 ? r_s[C-1:0] : r_a[C-1:0];
    if (w_pass2) begin
      w_y = r_mode[0] ? r_m[C-1:0] : ~r_m[C-1:0];
    end else begin
      w_y = r_mode[0] ? ~r_b[C-1:0] : r_b[C-1:0];
    end
    w_chunk   = {1'b0, w_x} + {1'b0, w_y} + {{C{1'b0}}, r_carry};
    w_s_shift = (r_s >> C) | (W'(w_chunk[C-1:0]) << (W - C));
    w_s_rot   = (r_s >> C) | (W'(r_s[C-1:0]) << (W - C));
    w_t_shift = (r_t >> C) | (W'(w_chunk[C-1:0]) << (W - C));
    // Subtraction leaves carry=1 when no borrow, so bit W is the inverted carry.
    w_pass1_res = {r_mode[0] ^ w_chunk[C], w_s_shift};
    // Mode 10 keeps s-m when {c1,s} >= m; mode 11 keeps s+m when a < b.
    w_take_t    = r_mode[0] ? ~r_c1 : (r_c1 | w_chunk[C]);
    w_pass2_res = {1'b0, w_take_t ? w_t_shift : w_s_rot};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = PASS1;
      PASS1:   if (w_last) w_state_next = r_mode[1] ? PASS2 : DONE;
      PASS2:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_s      <= '0;
      r_t      <= '0;
      r_mode   <= '0;
      r_carry  <= 1'b0;
      r_c1     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_m     <= in_m;
            r_s     <= '0;
            r_mode  <= mode;
            r_carry <= mode[0];
            r_cnt   <= '0;
          end
        end
        PASS1: begin
          r_a     <= r_a >> C;
          r_b     <= r_b >> C;
          r_s     <= w_s_shift;
          r_carry <= w_chunk[C];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt   <= '0;
            r_c1    <= w_chunk[C];
            r_carry <= ~r_mode[0];
            if (!r_mode[1]) begin
              r_result <= w_pass1_res;
            end
          end
        end
        PASS2: begin
          r_m     <= r_m >> C;
          r_s     <= w_s_rot;
          r_t     <= w_t_shift;
          r_carry <= w_chunk[C];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cnt    <= '0;
            r_result <= w_pass2_res;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = (r_state == DONE);
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mp_addsub.sv
// Directed bench for mp_addsub at W=512/C=64 and W=256/C=32.
// Cycle k is sampled on the falling edge between rising edges k-1 and k (edge 0 = accept).
module tb_mp_addsub;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start0, start1;
  logic [1:0]   mode0, mode1;
  logic [511:0] a0, b0, m0;
  logic [255:0] a1, b1, m1;
  logic [512:0] result0;
  logic [256:0] result1;
  logic         done0, done1, busy0, busy1;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  mp_addsub #(.OPERAND_WIDTH(512), .CHUNK_SIZE(64)) u_dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .mode(mode0),
    .in_a(a0), .in_b(b0), .in_m(m0),
    .result(result0), .done(done0), .busy(busy0)
  );

  mp_addsub #(.OPERAND_WIDTH(256), .CHUNK_SIZE(32)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .mode(mode1),
    .in_a(a1), .in_b(b1), .in_m(m1),
    .result(result1), .done(done1), .busy(busy1)
  );

  // Stimulus only: accept one op, scramble inputs afterwards, record done timing and result.
  task automatic run_op0(input logic [1:0] md, input logic [511:0] a, input logic [511:0] b,
                         input logic [511:0] m, output int dcyc, output int dcnt,
                         output logic [512:0] dres, output logic [512:0] hres);
    dcyc = -1; dcnt = 0; dres = '0;
    @(negedge clk);
    start0 = 1'b1; mode0 = md; a0 = a; b0 = b; m0 = m;
    @(posedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start0 = 1'b0; mode0 = ~md;
        a0 = {16{$urandom()}}; b0 = {16{$urandom()}}; m0 = {16{$urandom()}};
      end
      if (done0) begin dcnt++; dcyc = k; dres = result0; end
    end
    hres = result0;
  endtask

  task automatic run_op1(input logic [1:0] md, input logic [255:0] a, input logic [255:0] b,
                         output int dcyc, output int dcnt, output logic [256:0] dres);
    dcyc = -1; dcnt = 0; dres = '0;
    @(negedge clk);
    start1 = 1'b1; mode1 = md; a1 = a; b1 = b; m1 = '0;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin start1 = 1'b0; a1 = {8{$urandom()}}; b1 = {8{$urandom()}}; end
      if (done1) begin dcnt++; dcyc = k; dres = result1; end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start0 = 1'b0; mode0 = '0; a0 = '0; b0 = '0; m0 = '0;
    start1 = 1'b0; mode1 = '0; a1 = '0; b1 = '0; m1 = '0;
    repeat (3) @(negedge clk);
    total++; if (result0 !== '0) begin bad++; $display("FAIL reset_result0 got=%h want=0", result0); end
    total++; if ({done0, busy0} !== 2'b00) begin bad++; $display("FAIL reset_flags0 got=%b want=00", {done0, busy0}); end
    total++; if ({result1, done1, busy1} !== '0) begin bad++; $display("FAIL reset_dut1 got=%h want=0", {result1, done1, busy1}); end
    resetn = 1'b1;
  endtask

  task automatic test_add();
    int c, n; logic [512:0] r, h, e;
    run_op0(2'b00, '1, 512'd1, '0, c, n, r, h);
    e = '0; e[512] = 1'b1;
    total++; if (r !== e) begin bad++; $display("FAIL add_max result got=%h want=%h", r, e); end
    total++; if (c !== 9 || n !== 1) begin bad++; $display("FAIL add_max done got cycle=%0d pulses=%0d want cycle=9 pulses=1", c, n); end
    total++; if (h !== e) begin bad++; $display("FAIL add_max hold got=%h want=%h", h, e); end
    run_op0(2'b00, 512'hFFFF_FFFF_FFFF_FFFF, 512'd1, '0, c, n, r, h);
    e = '0; e[64] = 1'b1;
    total++; if (r !== e) begin bad++; $display("FAIL add_chunk_carry got=%h want=%h", r, e); end
    run_op0(2'b00, 512'h1234, 512'h1111, '0, c, n, r, h);
    total++; if (r !== 513'h2345) begin bad++; $display("FAIL add_small got=%h want=2345", r); end
  endtask

  task automatic test_sub();
    int c, n; logic [512:0] r, h, e;
    run_op0(2'b01, 512'd5, 512'd7, '0, c, n, r, h);
    e = '1; e = e - 513'd1;
    total++; if (r !== e) begin bad++; $display("FAIL sub_neg got=%h want=%h", r, e); end
    total++; if (c !== 9 || n !== 1) begin bad++; $display("FAIL sub_neg done got cycle=%0d pulses=%0d want cycle=9 pulses=1", c, n); end
    run_op0(2'b01, 512'd7, 512'd5, '0, c, n, r, h);
    total++; if (r !== 513'd2) begin bad++; $display("FAIL sub_pos got=%h want=2", r); end
  endtask

  task automatic test_modadd();
    int c, n; logic [512:0] r, h; logic [511:0] mm;
    mm = '1; mm = mm - 512'd2;
    run_op0(2'b10, mm - 512'd1, 512'd2, mm, c, n, r, h);
    total++; if (r !== 513'd1) begin bad++; $display("FAIL modadd_wrap got=%h want=1", r); end
    total++; if (c !== 17 || n !== 1) begin bad++; $display("FAIL modadd done got cycle=%0d pulses=%0d want cycle=17 pulses=1", c, n); end
    run_op0(2'b10, 512'd1, 512'd2, mm, c, n, r, h);
    total++; if (r !== 513'd3) begin bad++; $display("FAIL modadd_nowrap got=%h want=3", r); end
    run_op0(2'b10, mm - 512'd1, mm - 512'd1, mm, c, n, r, h);
    total++; if (r !== {1'b0, mm - 512'd2}) begin bad++; $display("FAIL modadd_carry got=%h want=%h", r, {1'b0, mm - 512'd2}); end
  endtask

  task automatic test_modsub();
    int c, n; logic [512:0] r, h;
    run_op0(2'b11, 512'd3, 512'd5, 512'd11, c, n, r, h);
    total++; if (r !== 513'd9) begin bad++; $display("FAIL modsub_neg got=%h want=9", r); end
    total++; if (c !== 17 || n !== 1) begin bad++; $display("FAIL modsub done got cycle=%0d pulses=%0d want cycle=17 pulses=1", c, n); end
    run_op0(2'b11, 512'd5, 512'd3, 512'd11, c, n, r, h);
    total++; if (r !== 513'd2) begin bad++; $display("FAIL modsub_pos got=%h want=2", r); end
  endtask

  task automatic test_start_ignore();
    int c = -1, n = 0; logic [512:0] r = '0;
    @(negedge clk);
    start0 = 1'b1; mode0 = 2'b00; a0 = 512'd100; b0 = 512'd23;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      total++;
      if (busy0 !== (k <= 9)) begin bad++; $display("FAIL busy cycle=%0d got=%b want=%b", k, busy0, (k <= 9)); end
      if (done0) begin n++; c = k; r = result0; end
      start0 = (k == 3 || k == 9);
      a0 = {16{$urandom()}}; b0 = {16{$urandom()}};
    end
    total++; if (c !== 9 || n !== 1) begin bad++; $display("FAIL restart done got cycle=%0d pulses=%0d want cycle=9 pulses=1", c, n); end
    total++; if (r !== 513'd123) begin bad++; $display("FAIL restart result got=%h want=7b", r); end
    total++; if (result0 !== 513'd123) begin bad++; $display("FAIL restart hold got=%h want=7b", result0); end
  endtask

  task automatic test_reset_abort();
    int c, n, seen = 0; logic [512:0] r, h;
    @(negedge clk);
    start0 = 1'b1; mode0 = 2'b10; a0 = 512'd5; b0 = 512'd6; m0 = 512'd100;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL abort busy_before got=%b want=1", busy0); end
    resetn = 1'b0;
    #1;
    total++; if ({result0, done0, busy0} !== '0) begin bad++; $display("FAIL abort outputs got=%h want=0", {result0, done0, busy0}); end
    repeat (3) begin @(negedge clk); if (done0) seen++; end
    resetn = 1'b1;
    repeat (20) begin @(negedge clk); if (done0) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort no_done got=%0d want=0", seen); end
    run_op0(2'b00, 512'd10, 512'd20, '0, c, n, r, h);
    total++; if (r !== 513'd30 || c !== 9) begin bad++; $display("FAIL after_abort got=%h cycle=%0d want=1e cycle=9", r, c); end
  endtask

  task automatic test_small();
    int c, n; logic [256:0] r, e;
    run_op1(2'b00, '1, 256'd1, c, n, r);
    e = '0; e[256] = 1'b1;
    total++; if (r !== e) begin bad++; $display("FAIL w256_add got=%h want=%h", r, e); end
    total++; if (c !== 9 || n !== 1) begin bad++; $display("FAIL w256_add done got cycle=%0d pulses=%0d want cycle=9 pulses=1", c, n); end
    run_op1(2'b01, 256'd5, 256'd7, c, n, r);
    e = '1; e = e - 257'd1;
    total++; if (r !== e) begin bad++; $display("FAIL w256_sub_neg got=%h want=%h", r, e); end
    run_op1(2'b01, 256'd7, 256'd5, c, n, r);
    total++; if (r !== 257'd2) begin bad++; $display("FAIL w256_sub_pos got=%h want=2", r); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_modadd();
    test_modsub();
    test_start_ignore();
    test_reset_abort();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
